// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and default widths/timeout for the APB master
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with a pready timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic              pwrite_q, pwrite_d, err_q, err_d;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = state_q == ACCESS;
    assign rsp_valid = state_q == RESP;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign cnt_inc   = cnt_q + 8'd1;

    // next state, command capture, wait counting and response capture
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                paddr_d  = cmd_addr;
                pwdata_d = cmd_wdata;
                pwrite_d = cmd_write;
                cnt_d    = '0;
                state_d  = SETUP;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (pready) begin
                rdata_d = pwrite_q ? '0 : prdata;
                err_d   = 1'b0;
                state_d = RESP;
            end else begin
                cnt_d = cnt_inc;
                if (cnt_inc == 8'(TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench for apb_master with a delay-programmable APB responder
module tb_apb_master;
    localparam int TMO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          nacc;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata = '0;
    logic        pwrite, psel, penable, pready = 1'b0;

    logic [31:0] mem     [16] = '{default: 32'h0};
    logic [31:0] exp_mem [16] = '{default: 32'h0};
    exp_t        sb[$];
    int          delay_cfg = 0, acc_cnt = 0;
    int          chk = 0, pass = 0;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    // responder: pready after delay_cfg waited ACCESS cycles, noise outside ACCESS
    always @(negedge clk) begin
        if (psel && penable) begin
            pready = (acc_cnt == delay_cfg);
            prdata = (pready && !pwrite) ? mem[paddr[5:2]] : 32'hBAD0_BAD0;
            if (pready && pwrite) mem[paddr[5:2]] = pwdata;
            acc_cnt++;
        end else begin
            pready  = 1'($urandom);
            prdata  = $urandom;
            acc_cnt = 0;
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input int hold, input bit poke, input string tag);
        exp_t        e, got;
        int          cyc, ns, na;
        bit          ok, moved, bad;
        logic [31:0] r0;
        ok     = delay >= 0 && delay < TMO;
        e.err  = !ok;
        e.nacc = ok ? delay + 1 : TMO;
        e.rdata = (ok && !wr) ? exp_mem[addr[5:2]] : 32'h0;
        if (ok && wr) exp_mem[addr[5:2]] = wdata;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; delay_cfg = delay;
        chk++; if (cmd_ready !== 1'b1) $display("FAIL %s accept: cmd_ready=%b exp 1", tag, cmd_ready); else pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0; ns = 0; na = 0; moved = 0;
        while (!rsp_valid && cyc < 100) begin
            if (psel && !penable) ns++;
            if (psel && penable) na++;
            if (psel && (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata))) moved = 1;
            if (cmd_ready !== 1'b0) moved = 1;
            @(negedge clk);
            cyc++;
        end
        got = sb.pop_front();
        chk++; if (cyc !== got.nacc + 1) $display("FAIL %s latency: cycles=%0d exp %0d", tag, cyc, got.nacc + 1); else pass++;
        chk++; if (ns !== 1) $display("FAIL %s setup: cycles=%0d exp 1", tag, ns); else pass++;
        chk++; if (na !== got.nacc) $display("FAIL %s access: cycles=%0d exp %0d", tag, na, got.nacc); else pass++;
        chk++; if (moved !== 1'b0) $display("FAIL %s stable: addr/ctrl moved=%b exp 0", tag, moved); else pass++;
        chk++; if ({psel, penable, cmd_ready} !== 3'b000) $display("FAIL %s resp_bus: psel,penable,cmd_ready=%b exp 000", tag, {psel, penable, cmd_ready}); else pass++;
        r0 = rsp_rdata;
        if (poke) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
        end
        bad = 0;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || cmd_ready !== 1'b0 || psel !== 1'b0) bad = 1;
        end
        if (hold > 0) begin
            chk++; if (bad !== 1'b0) $display("FAIL %s backpressure: unstable=%b exp 0", tag, bad); else pass++;
        end
        rsp_ready = 1'b1;
        chk++; if (rsp_rdata !== got.rdata) $display("FAIL %s rdata: got %h exp %h", tag, rsp_rdata, got.rdata); else pass++;
        chk++; if (rsp_err !== got.err) $display("FAIL %s err: got %b exp %b", tag, rsp_err, got.err); else pass++;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (poke) begin
            chk++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL %s post_hs: cmd_ready,rsp_valid=%b exp 10", tag, {cmd_ready, rsp_valid}); else pass++;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk++; if ({psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready} !== 6'b0) $display("FAIL reset ctrl: %b exp 000000", {psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready}); else pass++;
        chk++; if ({paddr, pwdata, rsp_rdata} !== 96'h0) $display("FAIL reset data: %h exp 0", {paddr, pwdata, rsp_rdata}); else pass++;
        rst = 1'b0;
        #1;
        chk++; if (cmd_ready !== 1'b1) $display("FAIL reset release: cmd_ready=%b exp 1", cmd_ready); else pass++;
    endtask

    task automatic test_write;
        xfer(1'b1, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0, "write");
    endtask

    task automatic test_readback;
        xfer(1'b0, 32'h0, 32'h0, 0, 0, 1'b0, "readback");
    endtask

    task automatic test_timeout;
        xfer(1'b0, 32'h0, 32'h0, -1, 0, 1'b0, "timeout");
    endtask

    task automatic test_coincident;
        xfer(1'b1, 32'h10, 32'hA5A5_5A5A, 0, 0, 1'b0, "coin_wr");
        xfer(1'b0, 32'h10, 32'h0, TMO - 1, 0, 1'b0, "coin_rd");
    endtask

    task automatic test_backpressure;
        xfer(1'b0, 32'h10, 32'h0, 2, 5, 1'b1, "backpressure");
    endtask

    task automatic test_reset_access;
        int  cyc;
        bit  seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; delay_cfg = -1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!(psel && penable) && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk++; if (penable !== 1'b1) $display("FAIL rst_access reach: penable=%b exp 1", penable); else pass++;
        #2 rst = 1'b1;
        #1;
        chk++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0) $display("FAIL rst_access outputs: %b exp 0000", {psel, penable, rsp_valid, cmd_ready}); else pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk++; if (cmd_ready !== 1'b1) $display("FAIL rst_access release: cmd_ready=%b exp 1", cmd_ready); else pass++;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || psel) seen = 1;
        end
        chk++; if (seen !== 1'b0) $display("FAIL rst_access abandon: activity=%b exp 0", seen); else pass++;
        xfer(1'b0, 32'h0, 32'h0, 0, 0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++)
            xfer(1'($urandom), {26'h0, 4'($urandom), 2'b00}, $urandom, $urandom_range(0, 5), 0, 1'b0, "b2b");
    endtask

    initial begin
        test_reset;
        test_write;
        test_readback;
        test_timeout;
        test_coincident;
        test_backpressure;
        test_reset_access;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
